// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, control encoding and datapath widths.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_pipe_reg_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]        id_funct;
    ctrl_t             id_ctrl;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]        ex_funct;
    ctrl_t             ex_ctrl;
    logic              load_use_hazard;

    modport master (
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_shamt, id_funct, id_ctrl,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_ctrl, load_use_hazard
    );

    modport slave (
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_shamt, id_funct, id_ctrl,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_ctrl, load_use_hazard
    );
endinterface

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: pipeline field register, priority reset > flush > stall > load.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) r_q <= '0;
        else if (!stall) r_q <= d;
    end

    assign q = r_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush and load-use detect.
module id_ex_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    id_ex_pipe_reg_if.slave    bus
);
    localparam int DW = 4 * DATA_W;
    localparam int SW = 4 * REG_AW + 6;
    localparam int CW = $bits(ctrl_t);

    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_spec_q;
    logic [CW-1:0] w_ctrl_q;
    logic          w_valid_q;
    ctrl_t         w_ctrl_d;

    // An invalid decode slot must never reach EX with live control bits.
    assign w_ctrl_d = bus.id_valid ? bus.id_ctrl : CTRL_NOP;

    pipe_field_reg #(.W(DW)) u_data (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .d({bus.id_pc4, bus.id_rs_data, bus.id_rt_data, bus.id_imm}), .q(w_data_q)
    );

    pipe_field_reg #(.W(SW)) u_spec (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .d({bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct}), .q(w_spec_q)
    );

    pipe_field_reg #(.W(CW)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .d(w_ctrl_d), .q(w_ctrl_q)
    );

    pipe_field_reg #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .d(bus.id_valid), .q(w_valid_q)
    );

    assign {bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm} = w_data_q;
    assign {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funct} = w_spec_q;
    assign bus.ex_ctrl  = ctrl_t'(w_ctrl_q);
    assign bus.ex_valid = w_valid_q;

    assign bus.load_use_hazard = bus.id_valid & w_valid_q & bus.ex_ctrl.mem_read
                               & (bus.ex_rt != '0)
                               & ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed checks of load, stall, flush, reset and load-use detect.
module tb_id_ex_pipe_reg;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n, stall, flush;
    int   errors = 0;
    int   checks = 0;

    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [8:0] ctrl);
        bus.id_valid   = v;
        bus.id_pc4     = pc4;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
        bus.id_imm     = imm;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_shamt   = 5'd4;
        bus.id_funct   = 6'h20;
        bus.id_ctrl    = ctrl_t'(ctrl);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h44, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 9'h1FF);
        step(); step();
        chk("rst_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_pc4",   64'(bus.ex_pc4), 64'd0);
        chk("rst_imm",   64'(bus.ex_imm), 64'd0);
        chk("rst_rt",    64'(bus.ex_rt), 64'd0);
        chk("rst_funct", 64'(bus.ex_funct), 64'd0);
        chk("rst_ctrl",  64'(bus.ex_ctrl), 64'd0);
        chk("rst_haz",   64'(bus.load_use_hazard), 64'd0);

        rst_n = 1'b1;
        drive(1'b1, 32'h104, 32'h10, 32'h20, 32'hFFFF_FF80, 5'd8, 5'd9, 5'd10, 9'b1_0_0_0_0_1_0_00);
        step();
        chk("ld_imm",   64'(bus.ex_imm), 64'hFFFF_FF80);
        chk("ld_rsd",   64'(bus.ex_rs_data), 64'h10);
        chk("ld_ctrl",  64'(bus.ex_ctrl), 64'(9'b1_0_0_0_0_1_0_00));
        chk("ld_valid", 64'(bus.ex_valid), 64'd1);
        chk("ld_pc4",   64'(bus.ex_pc4), 64'h104);
        chk("ld_rd",    64'(bus.ex_rd), 64'd10);
        chk("ld_funct", 64'(bus.ex_funct), 64'h20);
        chk("ld_shamt", 64'(bus.ex_shamt), 64'd4);

        drive(1'b1, 32'h100, 32'hA1, 32'hAAAA, 32'h5, 5'd1, 5'd2, 5'd3, 9'b0_0_0_0_0_0_1_10);
        step();
        chk("A_pc4", 64'(bus.ex_pc4), 64'h100);
        stall = 1'b1;
        drive(1'b1, 32'h200, 32'hB1, 32'hBBBB, 32'h6, 5'd7, 5'd8, 5'd9, 9'b1_1_1_0_0_1_0_00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc4",  64'(bus.ex_pc4), 64'h100);
            chk("stall_rtd",  64'(bus.ex_rt_data), 64'hAAAA);
            chk("stall_rd",   64'(bus.ex_rd), 64'd3);
            chk("stall_ctrl", 64'(bus.ex_ctrl), 64'(9'b0_0_0_0_0_0_1_10));
        end
        stall = 1'b0;
        step();
        chk("B_pc4",  64'(bus.ex_pc4), 64'h200);
        chk("B_rtd",  64'(bus.ex_rt_data), 64'hBBBB);
        chk("B_rd",   64'(bus.ex_rd), 64'd9);
        chk("B_ctrl", 64'(bus.ex_ctrl), 64'(9'b1_1_1_0_0_1_0_00));

        flush = 1'b1; stall = 1'b1;
        step();
        chk("fl_ctrl",  64'(bus.ex_ctrl), 64'd0);
        chk("fl_valid", 64'(bus.ex_valid), 64'd0);
        chk("fl_pc4",   64'(bus.ex_pc4), 64'd0);
        chk("fl_imm",   64'(bus.ex_imm), 64'd0);
        chk("fl_rs",    64'(bus.ex_rs), 64'd0);
        flush = 1'b0; stall = 1'b0;

        drive(1'b1, 32'h300, 32'h1, 32'h2, 32'h8, 5'd2, 5'd5, 5'd0, 9'b1_1_1_0_0_1_0_00);
        step();
        chk("lw_rt", 64'(bus.ex_rt), 64'd5);
        bus.id_rs = 5'd5; bus.id_rt = 5'd0; #1;
        chk("haz_rs_match", 64'(bus.load_use_hazard), 64'd1);
        bus.id_rs = 5'd6; bus.id_rt = 5'd7; #1;
        chk("haz_nomatch", 64'(bus.load_use_hazard), 64'd0);
        bus.id_rs = 5'd0; bus.id_rt = 5'd5; #1;
        chk("haz_rt_match", 64'(bus.load_use_hazard), 64'd1);
        bus.id_valid = 1'b0; #1;
        chk("haz_id_inval", 64'(bus.load_use_hazard), 64'd0);

        drive(1'b1, 32'h304, 32'h1, 32'h2, 32'h8, 5'd2, 5'd0, 5'd0, 9'b1_1_1_0_0_1_0_00);
        step();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; #1;
        chk("haz_rt_zero", 64'(bus.load_use_hazard), 64'd0);

        drive(1'b1, 32'h308, 32'h1, 32'h2, 32'h8, 5'd2, 5'd5, 5'd0, 9'b1_0_0_0_0_1_0_00);
        step();
        bus.id_rs = 5'd5; #1;
        chk("haz_no_memrd", 64'(bus.load_use_hazard), 64'd0);

        drive(1'b1, 32'h400, 32'h3, 32'h4, 32'h9, 5'd5, 5'd5, 5'd1, 9'b1_1_1_0_0_1_0_00);
        step();
        chk("haz_pre_bubble", 64'(bus.load_use_hazard), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; #1;
        chk("haz_after_bubble", 64'(bus.load_use_hazard), 64'd0);

        drive(1'b1, 32'h500, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 9'b0_0_0_0_0_0_1_10);
        step();
        stall = 1'b1; rst_n = 1'b0;
        step();
        chk("rst_stall_pc4",   64'(bus.ex_pc4), 64'd0);
        chk("rst_stall_valid", 64'(bus.ex_valid), 64'd0);
        rst_n = 1'b1; stall = 1'b0;
        drive(1'b1, 32'h600, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 9'b0_0_0_0_0_0_1_10);
        step();
        chk("post_rst_pc4", 64'(bus.ex_pc4), 64'h600);

        drive(1'b0, 32'h700, 32'h0, 32'h0, 32'h1234, 5'd7, 5'd8, 5'd9, 9'h1FF);
        step();
        chk("inv_ctrl",  64'(bus.ex_ctrl), 64'd0);
        chk("inv_valid", 64'(bus.ex_valid), 64'd0);
        chk("inv_imm",   64'(bus.ex_imm), 64'h1234);
        chk("inv_rs",    64'(bus.ex_rs), 64'd7);
        chk("inv_pc4",   64'(bus.ex_pc4), 64'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register of the 5-stage pipelined CPU. It captures the decode-stage outputs (register-file read data, the 32-bit sign-extended immediate from the 16→32 extender, register specifiers, and control bits) and presents them to the execute stage one cycle later. It supports stall (hold) and flush (bubble insertion). It also produces the load-use hazard flag consumed by the hazard unit.

## Interface
Parameters:
- DATA_W, 32, datapath width (PC, register data, extended immediate)
- REG_AW, 5, register specifier width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hold all registered fields
- flush  in  1  load a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_pc4  in  DATA_W  PC+4 of the decoded instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  REG_AW  instruction fields
- id_funct  in  6  function field
- id_ctrl  in  9  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
- ex_valid  out  1  registered id_valid
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd, ex_shamt  out  REG_AW  registered copies
- ex_funct  out  6  registered copy
- ex_ctrl  out  9  registered control, same bit order as id_ctrl
- load_use_hazard  out  1  combinational load-use detect

## Operation
- Update priority at each rising edge: reset > flush > stall > load.
- Reset (rst_n=0): every ex_* output is 0, and ex_valid is 0.
- Flush: every ex_* output is 0 and ex_valid is 0. A zero ex_ctrl is a guaranteed no-op: no register write and no memory access.
- Stall (flush=0): all ex_* outputs hold their values, and the ID inputs are ignored.
- Load (neither flush nor stall): every ex_* output takes its id_* value. If id_valid=0, ex_ctrl is forced to 0, and data fields load normally.
- load_use_hazard = ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)), gated with id_valid.
- No arithmetic is performed; widths pass through unchanged, with no re-extension of id_imm.

## Timing
- Latency is 1 cycle, ID to EX.
- load_use_hazard is combinational from the current ex_* registers and the id_* inputs. It is valid in the same cycle and has no register.
- flush and stall both asserted: flush wins, and a bubble is loaded.
- rst_n low together with flush or stall: reset wins.
- Reset asserted mid-stall: outputs clear on the next edge. After reset deassertion, the first edge loads the ID inputs.
- Consecutive stalls hold indefinitely without value corruption.
- load_use_hazard is driven externally back into stall/flush. Standard usage is to stall IF/ID and flush ID/EX for 1 cycle. That 1-cycle bubble clears ex_valid, so the hazard deasserts on the next cycle.

## Structure
- Shared package cpu_pkg:
  - ctrl_t packed struct (9 bits, ordering above) and its CTRL_NOP = '0 constant
  - ALU_OP encodings: 2'b00 add, 2'b01 sub, 2'b10 R-type funct
  - REG_AW and DATA_W defaults
- One sub-module, pipe_field_reg: a parameterized-width register with rst_n, stall, flush, d, and q, implementing the priority rule. It is instantiated once per field group (data, specifiers, control, valid).

## Test plan
- Reset: hold rst_n=0 for 2 cycles with nonzero inputs. Expected: all ex_* = 0, ex_valid=0, load_use_hazard=0.
- Load: id_imm=32'hFFFF_FF80, id_rs_data=32'h0000_0010, id_ctrl=9'b1_0_0_0_0_1_0_00, id_valid=1. Expected on the next cycle: ex_imm=32'hFFFF_FF80, ex_rs_data=32'h10, ex_ctrl equal to the input.
- Stall: load value A, then assert stall for 3 cycles while the inputs change to B. Expected: outputs remain A. Deassert stall; outputs become B one cycle later.
- Flush with stall: flush=1 and stall=1 with valid inputs. Expected next cycle: ex_ctrl=0, ex_valid=0, all data fields 0.
- Load-use: register lw with ex_rt=5, mem_read=1, ex_valid=1.
  - Drive id_rs=5: load_use_hazard=1 in the same cycle.
  - Drive id_rs=0 with ex_rt=0: load_use_hazard=0.
  - Drive id_rs=6, id_rt=7: load_use_hazard=0.
- id_valid=0 load: id_ctrl all ones. Expected next cycle: ex_ctrl=0 and ex_valid=0, while data fields are captured.
